register_scan_unit: RTL and testbench

Sequential reader for the 16 x 32-bit `register_file`. On a `start` pulse it walks the register file's two read ports in pairs (even register on port A, odd on port B). It captures each pair and streams the 16 values out one at a time over a valid/ready handshake, each value tagged with its register index. It sits beside the data path as the debug/dump path and never drives the register file write side (`port_c`, `decoder_control`, `load_enable`).

---
 rtl/register_scan_unit.sv | 170 +++++++++++++++++
 tb/tb_register_scan_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_scan_unit.sv
// -----------------------------------------------------------------------------
// register_scan_unit
//
// Debug/dump reader for the 16 x 32-bit register file. On a start pulse it
// walks the file's two read ports one even/odd pair at a time (even register
// on port A, odd register on port B), snapshots each pair into local buffers
// and then streams the two values out over a valid/ready handshake, each
// tagged with its register index. It never touches the register file write
// side.
//
// Parameters
//   NUM_PAIRS   number of pairs scanned, starting from R0/R1 (1..8)
//
// Ports
//   clk         clock, rising edge active
//   reset_n     asynchronous active-low reset
//   start       begin a scan (sampled in IDLE only)
//   abort       terminate a scan, back to IDLE without a done pulse
//   port_a      register file read port A (combinational from a_select)
//   port_b      register file read port B (combinational from b_select)
//   a_select    {pair counter, 1'b0} to the register file
//   b_select    {pair counter, 1'b1} to the register file
//   out_data    value being offered
//   out_index   register number of out_data
//   out_valid   a value is offered
//   out_ready   sink accepts the offered value
//   busy        scan in progress (SELECT, EMIT_A, EMIT_B)
//   done        one-cycle pulse after the last transfer
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; counter and buffers keep last values
//   S_SELECT | selects driven from the pair counter; pair captured at exit
//   S_EMIT_A | offering buf_a (even register) until it is accepted
//   S_EMIT_B | offering buf_b (odd register); then next pair or DONE
//   S_DONE   | done pulse for one cycle, then IDLE
// -----------------------------------------------------------------------------
module register_scan_unit #(
    parameter int NUM_PAIRS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] port_a,
    input  logic [31:0] port_b,
    output logic [3:0]  a_select,
    output logic [3:0]  b_select,
    output logic [31:0] out_data,
    output logic [3:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EMIT_A = 3'd2,
        S_EMIT_B = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_PAIR = 3'(NUM_PAIRS - 1);

    state_t      state_q,  state_d;
    logic [2:0]  pair_q,   pair_d;
    logic [31:0] buf_a_q,  buf_a_d;
    logic [31:0] buf_b_q,  buf_b_d;
    logic        xfer;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pair_q  <= 3'd0;
            buf_a_q <= 32'd0;
            buf_b_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SELECT;
                    pair_d  = 3'd0;
                end
            end

            S_SELECT: begin
                // Selects come straight from pair_q, so the read ports have
                // been settled for the whole cycle; this edge is the snapshot.
                state_d = S_EMIT_A;
                buf_a_d = port_a;
                buf_b_d = port_b;
            end

            S_EMIT_A: begin
                if (xfer) begin
                    state_d = S_EMIT_B;
                end
            end

            S_EMIT_B: begin
                if (xfer) begin
                    if (pair_q == LAST_PAIR) begin
                        state_d = S_DONE;
                    end else begin
                        pair_d  = pair_q + 3'd1;
                        state_d = S_SELECT;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; counter and buffers are
        // left exactly as they were so a dump can still be inspected.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pair_d  = pair_q;
            buf_a_d = buf_a_q;
            buf_b_d = buf_b_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_select = {pair_q, 1'b0};
    assign b_select = {pair_q, 1'b1};

    // Both data and index only change on state/buffer updates, so they stay
    // bit-stable while a beat is stalled. Outside EMIT_B they show the A side,
    // which is 0/0 out of reset.
    assign out_data  = (state_q == S_EMIT_B) ? buf_b_q  : buf_a_q;
    assign out_index = (state_q == S_EMIT_B) ? b_select : a_select;

    assign out_valid = (state_q == S_EMIT_A) || (state_q == S_EMIT_B);
    assign busy      = (state_q == S_SELECT) || out_valid;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_register_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_register_scan_unit
//
// Bench for register_scan_unit. Two instances share a behavioural register
// file: u_dut0 scans all 8 pairs, u_dut1 scans 2 pairs. Expected beats are
// taken from a snapshot of the register file at scan start; expected transfer
// and done edges follow from "3 cycles per pair plus one per stall cycle".
// -----------------------------------------------------------------------------
module tb_register_scan_unit;

    logic        clk;
    logic        reset_n;
    logic [1:0]  start;
    logic [1:0]  abort;
    logic [1:0]  out_ready;
    logic [31:0] port_a    [2];
    logic [31:0] port_b    [2];
    logic [3:0]  a_select  [2];
    logic [3:0]  b_select  [2];
    logic [31:0] out_data  [2];
    logic [3:0]  out_index [2];
    logic [1:0]  out_valid;
    logic [1:0]  busy;
    logic [1:0]  done;

    logic [31:0] rf [16];

    int total = 0;
    int bad   = 0;

    assign port_a[0] = rf[a_select[0]];
    assign port_b[0] = rf[b_select[0]];
    assign port_a[1] = rf[a_select[1]];
    assign port_b[1] = rf[b_select[1]];

    register_scan_unit #(.NUM_PAIRS(8)) u_dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start[0]),
        .abort     (abort[0]),
        .port_a    (port_a[0]),
        .port_b    (port_b[0]),
        .a_select  (a_select[0]),
        .b_select  (b_select[0]),
        .out_data  (out_data[0]),
        .out_index (out_index[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    register_scan_unit #(.NUM_PAIRS(2)) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start[1]),
        .abort     (abort[1]),
        .port_a    (port_a[1]),
        .port_b    (port_b[1]),
        .a_select  (a_select[1]),
        .b_select  (b_select[1]),
        .out_data  (out_data[1]),
        .out_index (out_index[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_values(input int w, input string tag);
        check({tag, "_a_select"},  32'(a_select[w]),  32'd0);
        check({tag, "_b_select"},  32'(b_select[w]),  32'd1);
        check({tag, "_out_data"},  out_data[w],       32'd0);
        check({tag, "_out_index"}, 32'(out_index[w]), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid[w]), 32'd0);
        check({tag, "_busy"},      32'(busy[w]),      32'd0);
        check({tag, "_done"},      32'(done[w]),      32'd0);
    endtask

    // ready_mode: 0 always ready, 1 toggle 1,0,1,0..., 2 random
    // ev:         0 none, 1 snapshot writes, 2 abort at index 7, 3 reset at index 10
    task automatic run_scan(input int w, input int np, input int ready_mode, input int ev);
        logic [31:0] exp_data [16];
        int          edge_n;
        int          beats;
        int          stalls;
        bit          prev_stall;
        logic [31:0] prev_d;
        logic [3:0]  prev_ix;
        bit          done_seen;
        bit          snap_done;
        bit          tog;
        bit          rdy;
        bit          v;
        logic [31:0] d;
        logic [3:0]  ix;

        for (int i = 0; i < 16; i++) exp_data[i] = rf[i];
        beats = 0; stalls = 0; prev_stall = 0; done_seen = 0;
        snap_done = 0; tog = 0; prev_d = '0; prev_ix = '0;

        @(negedge clk);
        start[w] = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1 start[w] = 1'b0;

        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       begin rdy = ~tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready[w] = rdy;

            @(negedge clk);
            v  = out_valid[w];
            d  = out_data[w];
            ix = out_index[w];

            if (prev_stall && v) begin
                check("stall_data_stable",  d,       prev_d);
                check("stall_index_stable", 32'(ix), 32'(prev_ix));
            end

            if (done[w]) begin
                check("done_edge",  edge_n, 3 * np + stalls);
                check("done_beats", beats,  2 * np);
                done_seen = 1;
            end

            if (v) begin
                check("busy_while_valid", 32'(busy[w]), 32'd1);
                if (ev == 1 && ix == 4'd4 && !snap_done) begin
                    rf[4] = 32'd50;
                    rf[10] = 32'd77;
                    exp_data[10] = 32'd77;
                    snap_done = 1;
                end
                if (ev == 2 && ix == 4'd7) begin
                    abort[w] = 1'b1;
                    @(posedge clk);
                    #1 abort[w] = 1'b0;
                    @(negedge clk);
                    check("abort_valid_low", 32'(out_valid[w]), 32'd0);
                    check("abort_busy_low",  32'(busy[w]),      32'd0);
                    for (int k = 0; k < 4; k++) begin
                        check("abort_no_done", 32'(done[w]), 32'd0);
                        @(negedge clk);
                    end
                    return;
                end
                if (ev == 3 && ix == 4'd10) begin
                    #2 reset_n = 1'b0;
                    #1 check_reset_values(w, "midreset");
                    #20 reset_n = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("post_reset_idle_valid", 32'(out_valid[w]), 32'd0);
                        check("post_reset_idle_busy",  32'(busy[w]),      32'd0);
                    end
                    return;
                end
                if (rdy) begin
                    check("beat_index", 32'(ix), beats);
                    check("beat_data",  d,       exp_data[beats]);
                    check("beat_edge",  edge_n + 1, 3 * (beats / 2) + 2 + (beats % 2) + stalls);
                    beats++;
                end else begin
                    stalls++;
                end
            end
            prev_stall = v && !rdy;
            prev_d     = d;
            prev_ix    = ix;

            if (!done_seen) begin
                @(posedge clk);
                edge_n++;
                #1;
            end
        end

        check("done_seen", 32'(done_seen), 32'd1);
        out_ready[w] = 1'b1;
        if (done_seen) begin
            @(posedge clk);
            @(negedge clk);
            check("after_done_pulse", 32'(done[w]),      32'd0);
            check("after_done_busy",  32'(busy[w]),      32'd0);
            check("after_done_valid", 32'(out_valid[w]), 32'd0);
        end
    endtask

    initial begin
        start     = '0;
        abort     = '0;
        out_ready = '0;
        for (int i = 0; i < 16; i++) rf[i] = 32'(100 + i);

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check_reset_values(0, "reset0");
        check_reset_values(1, "reset1");
        #19 reset_n = 1'b1;
        @(negedge clk);
        check_reset_values(0, "idle0");

        // full scan, always ready
        run_scan(0, 8, 0, 0);
        // same data with ready toggling
        run_scan(0, 8, 1, 0);
        // snapshot: R4 written after capture, R10 before its capture
        run_scan(0, 8, 0, 1);
        for (int i = 0; i < 16; i++) rf[i] = 32'(100 + i);
        // abort in EMIT_B of pair 3, then a clean rescan from R0
        run_scan(0, 8, 0, 2);
        run_scan(0, 8, 0, 0);
        // reset during pair 5
        run_scan(0, 8, 0, 3);
        // two-pair instance
        run_scan(1, 2, 0, 0);
        run_scan(1, 2, 2, 0);

        // randomized contents and backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) rf[i] = $urandom;
            run_scan(0, 8, 2, 0);
            run_scan(1, 2, 2, 0);
        end

        // start and abort together in IDLE: start wins
        out_ready[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        abort[0] = 1'b0;
        @(negedge clk);
        check("start_wins_busy", 32'(busy[0]), 32'd1);
        @(negedge clk);
        check("start_wins_valid", 32'(out_valid[0]), 32'd1);
        check("start_wins_index", 32'(out_index[0]), 32'd0);
        check("start_wins_data",  out_data[0],       rf[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
